data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port data memory between the CPU data port and a host port (debug/loader/DMA). The CPU has absolute priority: it cannot stall, so its access is never delayed. Host accesses use a req/gnt handshake, complete in free cycles, and return read data through a latency-matched tag pipeline. A starvation monitor flags a host that is locked out for too long.

Parameters:
AW, 14, memory address width (matches CPU dataAddress)
DW, 32, data width
RD_LAT, 1, memory read latency in cycles from address to mem_rdata; legal range 1..4
STARVE_LIM, 255, number of consecutive host wait cycles before host_starved sets; legal range 1..65535

Ports:
clk  in  1  clock
nRst  in  1  reset, synchronous, active-high
cpu_req  in  1  CPU accesses memory this cycle (decoded LOAD/STORE)
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data to CPU; equals mem_rdata, combinational
host_req  in  1  host access request; held with addr/we/wdata stable until host_gnt
host_we  in  1  host write enable
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  one-cycle pulse; host access issued to memory this cycle
host_rvalid  out  1  registered one-cycle pulse; host_rdata valid
host_rdata  out  DW  registered host read data; holds its value between reads
host_starved  out  1  registered starvation flag
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, RD_LAT cycles after mem_addr

Behaviour:
- Reset (nRst=1 at posedge): FSM goes to IDLE; tag pipe cleared; wait counter 0; host_rvalid 0; host_rdata 0; host_starved 0. While nRst=1: host_gnt=0, mem_we=0.
- Memory mux (combinational, same cycle):
  - cpu_req=1: mem_* take the cpu_* values.
  - Else, host issue condition (host_req=1 and FSM in IDLE or WAIT): mem_* take the host_* values and host_gnt=1.
  - Else: mem_we=0, and mem_addr/mem_wdata hold the cpu_* values.
- FSM states: IDLE, WAIT, RDWAIT.
  - IDLE: host_req=0 -> IDLE. host_req=1 with cpu_req=1 -> WAIT. Host issue with host_we=1 -> IDLE. Host issue with host_we=0 -> RDWAIT.
  - WAIT: same transitions as IDLE. host_req dropping to 0 before grant (protocol violation) -> IDLE with no access.
  - RDWAIT: host_req ignored, no gnt. Leaves to IDLE in the cycle the host read completes (host_rvalid rising edge).
  - Only one host read is outstanding at a time.
- Read tag pipe: shift register, RD_LAT+1 deep, marks host read issue. When data arrives (RD_LAT cycles after gnt): host_rdata <= mem_rdata, host_rvalid <= 1. host_rvalid is therefore high exactly RD_LAT+1 cycles after the gnt cycle. CPU reads are never tagged.
- Starvation counter: 16-bit.
  - Increments each cycle in WAIT with cpu_req=1; saturates at STARVE_LIM.
  - host_starved <= 1 when the counter reaches STARVE_LIM.
  - Counter and flag both clear on the cycle after host_gnt.
- Simultaneous CPU and host requests: CPU always wins. The host is served in the first cycle with cpu_req=0.
- Ordering: same-address accesses execute in issue order; the arbiter does no reordering or forwarding.
- Reset mid-read: tag pipe flush guarantees no host_rvalid for the aborted read.

Test Plan:
1. RD_LAT=1, mem[0x0010]=0xDEADBEEF, idle CPU, host read 0x0010 at cycle 0 -> host_gnt at cycle 0, host_rvalid at cycle 2, host_rdata=0xDEADBEEF, FSM back in IDLE.
2. Same cycle: CPU write 0x0020=0x00000001 and host write 0x0020=0x00000002 -> mem_we from CPU at cycle 0, host_gnt at cycle 1, final mem[0x0020]=0x00000002.
3. STARVE_LIM=4, cpu_req held high 6 cycles while host_req=1 -> host_starved=1 after the 4th wait cycle; gnt in cycle 6; host_starved=0 in cycle 7.
4. Host read issued with RD_LAT=3, nRst pulsed 1 cycle after gnt -> host_rvalid never asserts; all outputs at reset values; mem_we=0 during reset.
5. Back-to-back host reads with host_req held high, RD_LAT=2 -> second gnt only in the cycle the first host_rvalid pulses, never earlier; both data words correct.
6. CPU read 0x0003 with mem[0x0003]=0x12345678, host idle -> cpu_rdata=0x12345678 after RD_LAT; host_rvalid stays 0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the data memory arbiter: CPU data port, host req/gnt port
// and the single-port memory interface.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_mem_arbiter_if #(
   parameter int AW = 14,
   parameter int DW = 32
);

   // CPU data port
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;

   // Host port (debug / loader / DMA)
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          host_starved;

   // Single-port memory
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata,
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata, host_starved,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata,
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata, host_starved,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the CPU data
// port and a host port. The CPU always wins and is never delayed; the host is
// granted in the first CPU-free cycle, has at most one read outstanding, and
// gets its read data back through a tag pipe matched to the memory latency.
// A saturating wait counter raises host_starved when the host is locked out.
module data_mem_arbiter #(
   parameter int AW         = 14,
   parameter int DW         = 32,
   parameter int RD_LAT     = 1,     // 1..4
   parameter int STARVE_LIM = 255    // 1..65535
) (
   input logic               clk,
   input logic               nRst,   // synchronous, active-high
   data_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RDWAIT
   } state_t;

   localparam logic [15:0] STARVE_LIM_W = 16'(STARVE_LIM);

   state_t          state_q;
   logic [RD_LAT:0] tag_q;           // bit k set: host read issued k+1 cycles ago
   logic [15:0]     wait_cnt_q;
   logic [15:0]     wait_cnt_d;
   logic            host_starved_q;
   logic [DW-1:0]   host_rdata_q;

   logic            host_issue;
   logic            host_rd_issue;
   logic            rd_arrive;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_we;

   // The host may only issue when no host read is in flight and the CPU is idle.
   assign host_issue    = !nRst && bus.host_req && !bus.cpu_req &&
                          (state_q == ST_IDLE || state_q == ST_WAIT);
   assign host_rd_issue = host_issue && !bus.host_we;
   // Memory is presenting the tagged host read data in this cycle.
   assign rd_arrive     = tag_q[RD_LAT-1];

   // Memory mux: CPU first, then an issuing host, otherwise park on the CPU bus.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves it unassigned
      // and no latch is inferred.
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
      mem_we    = 1'b0;
      if (bus.cpu_req) begin
         mem_we = bus.cpu_we && !nRst;
      end else if (host_issue) begin
         mem_addr  = bus.host_addr;
         mem_wdata = bus.host_wdata;
         mem_we    = bus.host_we;
      end
   end

   // Next wait count: cleared by a grant, counts CPU-blocked WAIT cycles, saturates.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (host_issue) begin
         wait_cnt_d = '0;
      end else if (state_q == ST_WAIT && bus.host_req && bus.cpu_req &&
                   wait_cnt_q != STARVE_LIM_W) begin
         wait_cnt_d = wait_cnt_q + 16'd1;
      end
   end

   // Host FSM together with its starvation counter and registered flag.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous) and is active-high.
      if (nRst) begin
         state_q        <= ST_IDLE;
         wait_cnt_q     <= '0;
         host_starved_q <= 1'b0;
      end else begin
         // NOTE: all sequential state uses non-blocking assignments so every
         // register sees the pre-edge values of the others.
         unique case (state_q)
            ST_IDLE, ST_WAIT: begin
               if (!bus.host_req)     state_q <= ST_IDLE;
               else if (bus.cpu_req)  state_q <= ST_WAIT;
               else if (bus.host_we)  state_q <= ST_IDLE;
               else                   state_q <= ST_RDWAIT;
            end
            ST_RDWAIT: begin
               if (rd_arrive) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         wait_cnt_q <= wait_cnt_d;
         if (host_issue) begin
            host_starved_q <= 1'b0;
         end else if (wait_cnt_d == STARVE_LIM_W) begin
            host_starved_q <= 1'b1;
         end
      end
   end

   // Read tag pipe and host read-data capture; reset flushes any read in flight.
   always_ff @(posedge clk) begin
      if (nRst) begin
         tag_q        <= '0;
         host_rdata_q <= '0;
      end else begin
         tag_q <= {tag_q[RD_LAT-1:0], host_rd_issue};
         if (rd_arrive) begin
            host_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_addr     = mem_addr;
   assign bus.mem_wdata    = mem_wdata;
   assign bus.mem_we       = mem_we;
   assign bus.cpu_rdata    = bus.mem_rdata;
   assign bus.host_gnt     = host_issue;
   assign bus.host_rvalid  = tag_q[RD_LAT];
   assign bus.host_rdata   = host_rdata_q;
   assign bus.host_starved = host_starved_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a vector table for the memory mux,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_data_mem_arbiter;

   localparam int AW          = 14;
   localparam int DW          = 32;
   localparam int RD_LAT      = 2;
   localparam int STARVE_LIM  = 4;
   localparam int RAND_CYCLES = 3000;

   logic clk = 1'b0;
   logic nRst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   data_mem_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk (clk),
      .nRst(nRst),
      .bus (bus)
   );

   // Memory model: RD_LAT-cycle read latency, read-before-write on the same edge.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] rd_pipe [RD_LAT];
   logic          pre_we   = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   always @(posedge clk) begin
      rd_pipe[0] <= ram[bus.mem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (pre_we)           ram[pre_addr]     <= pre_data;
      else if (bus.mem_we)  ram[bus.mem_addr] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.cpu_req    = 1'b0;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = '0;
      bus.cpu_wdata  = '0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;
   endtask

   task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      pre_addr = addr;
      pre_data = data;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic cpu_read_check(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = addr;
      tick();
      bus.cpu_req  = 1'b0;
      repeat (RD_LAT - 1) tick();
      #2;
      check(name, bus.cpu_rdata, exp);
      check({name, "_rvalid"}, 32'(bus.host_rvalid), 0);
      tick();
   endtask

   typedef struct {
      logic rst;
      logic cpu_req;
      logic cpu_we;
      logic host_req;
      logic host_we;
      logic exp_gnt;
      logic exp_we;
      logic exp_host_sel;
   } vec_t;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } cpu_rd_t;

   vec_t          vecs [8];
   logic [DW-1:0] ref_mem [16];
   cpu_rd_t       cq [$];

   initial begin
      logic          seen;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic          exp_gnt;
      logic          exp_we;
      logic          h_pending;
      int            busy_until;
      int            rd_due;
      int            waits;
      int            pct;
      logic [DW-1:0] rd_exp;
      logic [DW-1:0] d;

      //              rst cpu cwe hst hwe  gnt we  hsel
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

      nRst = 1'b1;
      drive_idle();
      repeat (3) tick();
      nRst = 1'b0;
      #2;
      check("reset_rvalid",  32'(bus.host_rvalid),  0);
      check("reset_rdata",   bus.host_rdata,        0);
      check("reset_starved", 32'(bus.host_starved), 0);
      check("reset_gnt",     32'(bus.host_gnt),     0);
      check("reset_mem_we",  32'(bus.mem_we),       0);
      tick();

      // Memory mux vectors, each applied from IDLE
      for (int i = 0; i < 8; i++) begin
         nRst           = vecs[i].rst;
         bus.cpu_req    = vecs[i].cpu_req;
         bus.cpu_we     = vecs[i].cpu_we;
         bus.cpu_addr   = AW'(32'h100 + i);
         bus.cpu_wdata  = 32'hC000_0000 + i;
         bus.host_req   = vecs[i].host_req;
         bus.host_we    = vecs[i].host_we;
         bus.host_addr  = AW'(32'h200 + i);
         bus.host_wdata = 32'hB000_0000 + i;
         exp_addr  = vecs[i].exp_host_sel ? bus.host_addr  : bus.cpu_addr;
         exp_wdata = vecs[i].exp_host_sel ? bus.host_wdata : bus.cpu_wdata;
         #2;
         check($sformatf("vec%0d_gnt", i),   32'(bus.host_gnt), 32'(vecs[i].exp_gnt));
         check($sformatf("vec%0d_we", i),    32'(bus.mem_we),   32'(vecs[i].exp_we));
         check($sformatf("vec%0d_addr", i),  32'(bus.mem_addr), 32'(exp_addr));
         check($sformatf("vec%0d_wdata", i), bus.mem_wdata,     exp_wdata);
         tick();
         drive_idle();
         nRst = 1'b0;
         repeat (RD_LAT + 3) tick();
      end

      // 1: host read with an idle CPU, data RD_LAT+1 cycles after gnt
      preload(14'h010, 32'hDEADBEEF);
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 14'h010;
      #2;
      check("t1_gnt",      32'(bus.host_gnt), 1);
      check("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
      check("t1_mem_we",   32'(bus.mem_we),   0);
      tick();
      bus.host_req = 1'b0;
      for (int c = 1; c <= RD_LAT; c++) begin
         #2;
         check($sformatf("t1_early_rvalid_c%0d", c), 32'(bus.host_rvalid), 0);
         tick();
      end
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 14'h011;
      bus.host_wdata = 32'h0BAD_F00D;
      #2;
      check("t1_rvalid",      32'(bus.host_rvalid), 1);
      check("t1_rdata",       bus.host_rdata,       32'hDEADBEEF);
      check("t1_idle_regnt",  32'(bus.host_gnt),    1);
      tick();
      drive_idle();
      #2;
      check("t1_rvalid_pulse", 32'(bus.host_rvalid), 0);
      check("t1_rdata_hold",   bus.host_rdata,       32'hDEADBEEF);
      tick();

      // 2: same-cycle CPU and host writes to one address, host lands second
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = 1'b1;
      bus.cpu_addr   = 14'h020;
      bus.cpu_wdata  = 32'h1;
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 14'h020;
      bus.host_wdata = 32'h2;
      #2;
      check("t2_c0_we",    32'(bus.mem_we),   1);
      check("t2_c0_wdata", bus.mem_wdata,     32'h1);
      check("t2_c0_gnt",   32'(bus.host_gnt), 0);
      tick();
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      #2;
      check("t2_c1_gnt",   32'(bus.host_gnt), 1);
      check("t2_c1_we",    32'(bus.mem_we),   1);
      check("t2_c1_wdata", bus.mem_wdata,     32'h2);
      tick();
      drive_idle();
      cpu_read_check(14'h020, 32'h2, "t2_final_mem");

      // 3: starvation flag under a 6-cycle CPU burst
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 14'h030;
      bus.host_wdata = 32'h5A5A;
      for (int c = 0; c < 6; c++) begin
         bus.cpu_req  = 1'b1;
         bus.cpu_addr = 14'h031;
         #2;
         check($sformatf("t3_gnt_c%0d", c),     32'(bus.host_gnt),     0);
         check($sformatf("t3_starved_c%0d", c), 32'(bus.host_starved), 32'(c >= STARVE_LIM + 1));
         tick();
      end
      bus.cpu_req = 1'b0;
      #2;
      check("t3_gnt_c6",     32'(bus.host_gnt),     1);
      check("t3_starved_c6", 32'(bus.host_starved), 1);
      tick();
      bus.host_req = 1'b0;
      #2;
      check("t3_starved_c7", 32'(bus.host_starved), 0);
      tick();

      // 4: reset one cycle after a host read gnt aborts the read
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 14'h010;
      #2;
      check("t4_gnt", 32'(bus.host_gnt), 1);
      tick();
      nRst           = 1'b1;
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = 1'b1;
      bus.cpu_addr   = 14'h050;
      bus.cpu_wdata  = 32'h7777;
      bus.host_we    = 1'b1;
      #2;
      check("t4_rst_mem_we", 32'(bus.mem_we),   0);
      check("t4_rst_gnt",    32'(bus.host_gnt), 0);
      tick();
      nRst = 1'b0;
      drive_idle();
      seen = 1'b0;
      for (int c = 0; c < RD_LAT + 3; c++) begin
         #2;
         if (bus.host_rvalid) seen = 1'b1;
         tick();
      end
      check("t4_no_rvalid", 32'(seen), 0);
      #2;
      check("t4_rdata",   bus.host_rdata,        0);
      check("t4_starved", 32'(bus.host_starved), 0);
      tick();
      cpu_read_check(14'h050, 32'hx, "t4_no_write_in_reset");

      // 5: back-to-back host reads with host_req held high
      preload(14'h040, 32'hA1A1_0040);
      preload(14'h041, 32'hB2B2_0041);
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 14'h040;
      #2;
      check("t5_gnt0", 32'(bus.host_gnt), 1);
      tick();
      bus.host_addr = 14'h041;
      for (int c = 1; c <= RD_LAT; c++) begin
         #2;
         check($sformatf("t5_early_gnt_c%0d", c), 32'(bus.host_gnt), 0);
         tick();
      end
      #2;
      check("t5_rvalid0", 32'(bus.host_rvalid), 1);
      check("t5_rdata0",  bus.host_rdata,       32'hA1A1_0040);
      check("t5_gnt1",    32'(bus.host_gnt),    1);
      tick();
      drive_idle();
      for (int c = 1; c <= RD_LAT; c++) begin
         #2;
         check($sformatf("t5_gap_rvalid_c%0d", c), 32'(bus.host_rvalid), 0);
         tick();
      end
      #2;
      check("t5_rvalid1", 32'(bus.host_rvalid), 1);
      check("t5_rdata1",  bus.host_rdata,       32'hB2B2_0041);
      tick();

      // 6: plain CPU read, host idle
      preload(14'h003, 32'h12345678);
      cpu_read_check(14'h003, 32'h12345678, "t6_cpu_rdata");

      // Randomized traffic against a transaction-level model
      for (int a = 0; a < 16; a++) begin
         d = $urandom;
         preload(AW'(a), d);
         ref_mem[a] = d;
      end
      h_pending  = 1'b0;
      busy_until = 0;
      rd_due     = -1;
      rd_exp     = '0;
      waits      = 0;
      for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
         pct = (((cyc / 150) % 3) == 2) ? 95 : 35;
         bus.cpu_req   = ($urandom_range(0, 99) < pct);
         bus.cpu_we    = 1'($urandom_range(0, 1));
         bus.cpu_addr  = AW'($urandom_range(0, 15));
         bus.cpu_wdata = $urandom;
         if (!h_pending && $urandom_range(0, 99) < 50) begin
            h_pending      = 1'b1;
            bus.host_we    = 1'($urandom_range(0, 1));
            bus.host_addr  = AW'($urandom_range(0, 15));
            bus.host_wdata = $urandom;
         end
         bus.host_req = h_pending;

         exp_gnt   = h_pending && !bus.cpu_req && (cyc >= busy_until);
         exp_we    = bus.cpu_req ? bus.cpu_we : (exp_gnt && bus.host_we);
         exp_addr  = (!bus.cpu_req && exp_gnt) ? bus.host_addr  : bus.cpu_addr;
         exp_wdata = (!bus.cpu_req && exp_gnt) ? bus.host_wdata : bus.cpu_wdata;
         #2;
         check($sformatf("rnd_gnt_c%0d", cyc),     32'(bus.host_gnt),     32'(exp_gnt));
         check($sformatf("rnd_we_c%0d", cyc),      32'(bus.mem_we),       32'(exp_we));
         check($sformatf("rnd_addr_c%0d", cyc),    32'(bus.mem_addr),     32'(exp_addr));
         if (exp_we) check($sformatf("rnd_wdata_c%0d", cyc), bus.mem_wdata, exp_wdata);
         check($sformatf("rnd_rvalid_c%0d", cyc),  32'(bus.host_rvalid),  32'(cyc == rd_due));
         if (cyc == rd_due) check($sformatf("rnd_rdata_c%0d", cyc), bus.host_rdata, rd_exp);
         check($sformatf("rnd_starved_c%0d", cyc), 32'(bus.host_starved), 32'(waits > STARVE_LIM));
         if (cq.size() > 0 && cq[0].due == cyc) begin
            check($sformatf("rnd_cpu_rdata_c%0d", cyc), bus.cpu_rdata, cq[0].data);
            void'(cq.pop_front());
         end
         tick();

         if (bus.cpu_req) begin
            if (bus.cpu_we) ref_mem[bus.cpu_addr[3:0]] = bus.cpu_wdata;
            else cq.push_back('{due: cyc + RD_LAT, data: ref_mem[bus.cpu_addr[3:0]]});
         end else if (exp_gnt) begin
            if (bus.host_we) begin
               ref_mem[bus.host_addr[3:0]] = bus.host_wdata;
            end else begin
               rd_due     = cyc + RD_LAT + 1;
               rd_exp     = ref_mem[bus.host_addr[3:0]];
               busy_until = rd_due;
            end
         end
         if (exp_gnt) begin
            waits     = 0;
            h_pending = 1'b0;
         end else if (h_pending && bus.cpu_req && cyc >= busy_until) begin
            waits++;
         end
      end
      drive_idle();
      repeat (RD_LAT + 3) tick();
      for (int a = 0; a < 16; a++) begin
         cpu_read_check(AW'(a), ref_mem[a], $sformatf("rnd_final_mem%0d", a));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
